// File: rtl/dds_cmd_sched.sv
// Shares the cmd_decoder command port between the buffered SPI host and the
// on-chip oscillator-0 frequency-sweep engine; host has priority, sweep has a starvation guard.
module dds_cmd_sched #(
  parameter int DATAWORD_WIDTH = 16,
  parameter int TUNING_WIDTH   = 14,
  parameter int DWELL_WIDTH    = 16,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [7:0]                host_cmd,
  input  logic [DATAWORD_WIDTH-1:0] host_data,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [TUNING_WIDTH-1:0]   sweep_start,
  input  logic [TUNING_WIDTH-1:0]   sweep_stop,
  input  logic [TUNING_WIDTH-1:0]   sweep_step,
  input  logic [DWELL_WIDTH-1:0]    sweep_dwell,
  input  logic                      sweep_go,
  input  logic                      sweep_abort,
  output logic [7:0]                cmd_word,
  output logic [DATAWORD_WIDTH-1:0] data_word,
  output logic                      cmd_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DWELL,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic                      hold_full;
  logic [7:0]                hold_cmd;
  logic [DATAWORD_WIDTH-1:0] hold_data;
  logic                      osc1_shadow;

  logic [TUNING_WIDTH-1:0]   cur, stop_r, step_r;
  logic                      dir_up;
  logic [DWELL_WIDTH-1:0]    dwell_r, dwell_cnt;
  logic [STARVE_W-1:0]       starve_cnt;

  logic                      host_accept, go_accept;
  logic                      sweep_req, sweep_grant, host_grant;
  logic [TUNING_WIDTH:0]     sum_ext, diff_ext;
  logic [TUNING_WIDTH-1:0]   cur_next;
  logic [7:0]                sweep_cmd;

  assign host_ready  = ~hold_full;
  assign host_accept = host_valid & ~hold_full;
  assign go_accept   = (state == S_IDLE) & sweep_go & ~sweep_abort;
  assign sweep_cmd   = {3'b000, osc1_shadow, 2'b00, 2'b11};

  // Abort suppresses the sweep grant so the port can fall to the host that cycle.
  always_comb begin
    sweep_req   = (state == S_ISSUE);
    sweep_grant = sweep_req & ~sweep_abort &
                  (~hold_full | (starve_cnt == STARVE_W'(STARVE_LIMIT)));
    host_grant  = hold_full & ~sweep_grant;
  end

  // One extra bit catches wrap-around; either direction then clamps to stop.
  always_comb begin
    sum_ext  = {1'b0, cur} + {1'b0, step_r};
    diff_ext = {1'b0, cur} - {1'b0, step_r};
    cur_next = stop_r;
    if (dir_up) begin
      if (sum_ext <= {1'b0, stop_r}) cur_next = sum_ext[TUNING_WIDTH-1:0];
    end else begin
      if (!diff_ext[TUNING_WIDTH] && (diff_ext[TUNING_WIDTH-1:0] >= stop_r))
        cur_next = diff_ext[TUNING_WIDTH-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (sweep_go) state_next = S_ISSUE;
      S_ISSUE:  if (sweep_grant) state_next = (cur == stop_r) ? S_FINISH : S_DWELL;
      S_DWELL:  if (dwell_cnt == dwell_r) state_next = S_ISSUE;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (sweep_abort) state_next = S_IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cur       <= '0;
      stop_r    <= '0;
      step_r    <= '0;
      dir_up    <= 1'b0;
      dwell_r   <= '0;
      dwell_cnt <= '0;
    end else if (go_accept) begin
      cur       <= sweep_start;
      stop_r    <= sweep_stop;
      step_r    <= (sweep_step == '0) ? TUNING_WIDTH'(1) : sweep_step;
      dwell_r   <= (sweep_dwell == '0) ? DWELL_WIDTH'(1) : sweep_dwell;
      dir_up    <= (sweep_start <= sweep_stop);
    end else if (sweep_grant && (cur != stop_r)) begin
      cur       <= cur_next;
      dwell_cnt <= DWELL_WIDTH'(1);
    end else if (state == S_DWELL) begin
      dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                                      starve_cnt <= '0;
    else if (sweep_grant || (state_next != S_ISSUE))  starve_cnt <= '0;
    else if (sweep_req)                               starve_cnt <= starve_cnt + STARVE_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_full <= 1'b0;
      hold_cmd  <= '0;
      hold_data <= '0;
    end else if (host_accept) begin
      hold_full <= 1'b1;
      hold_cmd  <= host_cmd;
      hold_data <= host_data;
    end else if (host_grant) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd_valid   <= 1'b0;
      cmd_word    <= '0;
      data_word   <= '0;
      osc1_shadow <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cmd_valid <= sweep_grant | host_grant;
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_FINISH);
      if (sweep_grant) begin
        cmd_word  <= sweep_cmd;
        data_word <= DATAWORD_WIDTH'(cur);
      end else if (host_grant) begin
        cmd_word    <= hold_cmd;
        data_word   <= hold_data;
        osc1_shadow <= hold_cmd[4];
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_sched.sv
// Self-checking bench for dds_cmd_sched: transaction-level reference model,
// per-cycle comparison, directed literal scenarios, then randomized traffic.
module tb_dds_cmd_sched;

  localparam int STARVE = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  host_cmd;
  logic [15:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic [13:0] sweep_start, sweep_stop, sweep_step;
  logic [15:0] sweep_dwell;
  logic        sweep_go, sweep_abort;
  logic [7:0]  cmd_word;
  logic [15:0] data_word;
  logic        cmd_valid, busy, done;

  dds_cmd_sched #(
    .DATAWORD_WIDTH(16),
    .TUNING_WIDTH(14),
    .DWELL_WIDTH(16),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .host_cmd(host_cmd), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready),
    .sweep_start(sweep_start), .sweep_stop(sweep_stop), .sweep_step(sweep_step),
    .sweep_dwell(sweep_dwell), .sweep_go(sweep_go), .sweep_abort(sweep_abort),
    .cmd_word(cmd_word), .data_word(data_word), .cmd_valid(cmd_valid),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a one-slot host queue plus a sweep described as
  // "active / wants the port / waiting N cycles / finishing".
  int          m_cyc = 0;
  bit          model_ok = 0;
  bit          m_hold_full;
  logic [7:0]  m_hold_cmd;
  logic [15:0] m_hold_data;
  bit          m_osc1;
  int          m_starve;
  bit          sw_on, sw_req, sw_fin, sw_up;
  int          sw_cur, sw_stop, sw_step, sw_dwell, sw_wait;
  bit          exp_valid, exp_busy, exp_done;
  logic [7:0]  exp_cmd;
  logic [15:0] exp_data;
  bit          m_sreq, m_sg, m_hg, m_acc;
  int          m_n;

  always @(posedge sys_clk) begin
    m_cyc++;
    if (sys_rst) begin
      model_ok = 1; m_hold_full = 0; m_osc1 = 0; m_starve = 0;
      sw_on = 0; sw_req = 0; sw_fin = 0;
      exp_valid = 0; exp_busy = 0; exp_done = 0;
    end else begin
      m_sreq = sw_on && sw_req;
      m_sg   = m_sreq && !sweep_abort && (!m_hold_full || m_starve == STARVE);
      m_hg   = m_hold_full && !m_sg;
      m_acc  = host_valid && !m_hold_full;
      exp_valid = m_sg || m_hg;
      if (m_sg) begin
        exp_cmd  = 8'h03 | (m_osc1 ? 8'h10 : 8'h00);
        exp_data = 16'(sw_cur);
      end
      if (m_hg) begin
        exp_cmd  = m_hold_cmd;
        exp_data = m_hold_data;
        m_osc1   = m_hold_cmd[4];
      end
      if (m_acc) begin
        m_hold_full = 1; m_hold_cmd = host_cmd; m_hold_data = host_data;
      end else if (m_hg) m_hold_full = 0;
      if (m_sreq && !m_sg && !sweep_abort) m_starve++;
      else m_starve = 0;

      if (sweep_abort) begin
        sw_on = 0; sw_req = 0; sw_fin = 0;
      end else if (!sw_on) begin
        if (sweep_go) begin
          sw_on = 1; sw_req = 1; sw_fin = 0;
          sw_cur   = int'(sweep_start);
          sw_stop  = int'(sweep_stop);
          sw_step  = (sweep_step == 0) ? 1 : int'(sweep_step);
          sw_dwell = (sweep_dwell == 0) ? 1 : int'(sweep_dwell);
          sw_up    = (sw_cur <= sw_stop);
        end
      end else if (sw_fin) begin
        sw_on = 0; sw_fin = 0;
      end else if (sw_req) begin
        if (m_sg) begin
          sw_req = 0;
          if (sw_cur == sw_stop) sw_fin = 1;
          else begin
            m_n = sw_up ? sw_cur + sw_step : sw_cur - sw_step;
            if (sw_up && m_n > sw_stop) m_n = sw_stop;
            if (!sw_up && m_n < sw_stop) m_n = sw_stop;
            sw_cur  = m_n;
            sw_wait = sw_dwell;
          end
        end
      end else begin
        sw_wait--;
        if (sw_wait == 0) sw_req = 1;
      end
      exp_busy = sw_on;
      exp_done = sw_fin;
    end
  end

  // Per-cycle compare plus a capture of observed strobes for directed checks.
  int         cap_data[$];
  int         cap_cmd[$];
  int         cap_cyc[$];
  int         done_cnt = 0;

  always @(negedge sys_clk) begin
    if (model_ok) begin
      chk("cmd_valid", cmd_valid, exp_valid);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("host_ready", host_ready, !m_hold_full);
      if (exp_valid) begin
        chk("cmd_word", cmd_word, exp_cmd);
        chk("data_word", data_word, exp_data);
      end
      if (cmd_valid === 1'b1) begin
        cap_data.push_back(int'(data_word));
        cap_cmd.push_back(int'(cmd_word));
        cap_cyc.push_back(m_cyc);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  int go_cyc, done_base;

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1; host_valid = 0; sweep_go = 0; sweep_abort = 0;
    @(negedge sys_clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_word", cmd_word, 0);
    chk("rst_data_word", data_word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_host_ready", host_ready, 1);
    sys_rst = 0;
  endtask

  task automatic clear_caps();
    cap_data.delete(); cap_cmd.delete(); cap_cyc.delete();
    done_base = done_cnt;
  endtask

  task automatic run_sweep(input int s, input int e, input int st, input int dw, input int regrab);
    bit got;
    clear_caps();
    @(negedge sys_clk);
    go_cyc = m_cyc;
    sweep_start = 14'(s); sweep_stop = 14'(e); sweep_step = 14'(st); sweep_dwell = 16'(dw);
    sweep_go = 1;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge sys_clk);
      if (regrab > 0 && i == regrab) begin
        sweep_start = 14'd0; sweep_stop = 14'd1; sweep_go = 1;
      end else sweep_go = 0;
      if (done === 1'b1) got = 1;
    end
    sweep_go = 0;
    chk("sweep_done_seen", got, 1);
    @(negedge sys_clk);
    chk("busy_after_done", busy, 0);
    chk("done_pulses", done_cnt - done_base, 1);
  endtask

  task automatic check_caps(input string tag, input int n, input int v0, input int v1,
                            input int v2, input int v3, input int cmd);
    int v[4];
    v = '{v0, v1, v2, v3};
    chk({tag, "_count"}, cap_data.size(), n);
    for (int i = 0; i < n && i < cap_data.size(); i++) begin
      chk({tag, "_data"}, cap_data[i], v[i]);
      chk({tag, "_cmd"}, cap_cmd[i], cmd);
    end
  endtask

  task automatic send_host(input logic [7:0] c, input logic [15:0] d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge sys_clk);
      if (host_ready === 1'b1) ok = 1;
    end
    chk("host_ready_wait", ok, 1);
    host_cmd = c; host_data = d; host_valid = 1;
    @(negedge sys_clk);
    host_valid = 0;
  endtask

  initial begin
    sys_rst = 1; host_cmd = 0; host_data = 0; host_valid = 0;
    sweep_start = 0; sweep_stop = 0; sweep_step = 0; sweep_dwell = 0;
    sweep_go = 0; sweep_abort = 0;
    repeat (2) @(negedge sys_clk);
    do_reset();

    // Host command latency: accepted in N, strobe in N+2.
    @(negedge sys_clk);
    host_cmd = 8'h13; host_data = 16'h0123; host_valid = 1;
    @(negedge sys_clk);
    host_valid = 0;
    chk("host_ready_held", host_ready, 0);
    chk("host_no_early_strobe", cmd_valid, 0);
    @(negedge sys_clk);
    chk("host_strobe", cmd_valid, 1);
    chk("host_cmd_word", cmd_word, 8'h13);
    chk("host_data_word", data_word, 16'h0123);
    @(negedge sys_clk);
    chk("host_single_strobe", cmd_valid, 0);
    do_reset();

    run_sweep(100, 130, 10, 3, 0);
    check_caps("up_sweep", 4, 100, 110, 120, 130, 8'h03);
    chk("sweep_first_latency", cap_cyc[0] - go_cyc, 2);
    chk("sweep_strobe_gap", cap_cyc[1] - cap_cyc[0], 4);
    chk("sweep_strobe_gap2", cap_cyc[3] - cap_cyc[2], 4);

    run_sweep(20, 5, 7, 1, 0);
    check_caps("down_sweep", 4, 20, 13, 6, 5, 8'h03);
    run_sweep(14'h3FF0, 14'h3FFF, 14'h20, 2, 0);
    check_caps("ovf_sweep", 2, 14'h3FF0, 14'h3FFF, 0, 0, 8'h03);
    run_sweep(50, 50, 5, 2, 0);
    check_caps("single_sweep", 1, 50, 0, 0, 0, 8'h03);
    run_sweep(7, 10, 0, 0, 0);
    check_caps("step0_sweep", 4, 7, 8, 9, 10, 8'h03);
    chk("dwell0_gap", cap_cyc[1] - cap_cyc[0], 2);
    run_sweep(200, 230, 10, 5, 4);
    check_caps("go_while_busy", 4, 200, 210, 220, 230, 8'h03);

    // osc1 enable picked up from a host command is preserved in sweep words.
    send_host(8'h10, 16'h0000);
    repeat (3) @(negedge sys_clk);
    run_sweep(1, 1, 1, 1, 0);
    check_caps("osc1_preserve", 1, 1, 0, 0, 0, 8'h13);

    // Abort during DWELL.
    clear_caps();
    @(negedge sys_clk);
    sweep_start = 100; sweep_stop = 200; sweep_step = 10; sweep_dwell = 6; sweep_go = 1;
    @(negedge sys_clk); sweep_go = 0;
    @(negedge sys_clk);
    @(negedge sys_clk); sweep_abort = 1;
    @(negedge sys_clk); sweep_abort = 0;
    chk("abort_dwell_busy", busy, 0);
    repeat (20) @(negedge sys_clk);
    chk("abort_dwell_strobes", cap_data.size(), 1);
    chk("abort_dwell_done", done_cnt - done_base, 0);

    // Abort in the same cycle as the sweep grant.
    clear_caps();
    @(negedge sys_clk);
    sweep_start = 300; sweep_stop = 300; sweep_go = 1;
    @(negedge sys_clk); sweep_go = 0; sweep_abort = 1;
    chk("abort_grant_busy_before", busy, 1);
    @(negedge sys_clk); sweep_abort = 0;
    chk("abort_grant_busy", busy, 0);
    chk("abort_grant_no_strobe", cmd_valid, 0);
    repeat (10) @(negedge sys_clk);
    chk("abort_grant_strobes", cap_data.size(), 0);
    chk("abort_grant_done", done_cnt - done_base, 0);

    // Reset mid-sweep with a host command sitting in the hold register.
    @(negedge sys_clk);
    sweep_start = 10; sweep_stop = 90; sweep_step = 10; sweep_dwell = 3; sweep_go = 1;
    @(negedge sys_clk); sweep_go = 0;
    repeat (3) @(negedge sys_clk);
    host_cmd = 8'h55; host_data = 16'hBEEF; host_valid = 1;
    do_reset();
    clear_caps();
    repeat (8) @(negedge sys_clk);
    chk("post_reset_strobes", cap_data.size(), 0);

    // Host pressing back-to-back while a sweep is running.
    @(negedge sys_clk);
    sweep_start = 1000; sweep_stop = 1100; sweep_step = 25; sweep_dwell = 1; sweep_go = 1;
    for (int i = 0; i < 40; i++) begin
      host_valid = 1; host_cmd = 8'($urandom); host_data = 16'($urandom);
      @(negedge sys_clk);
      sweep_go = 0;
    end
    host_valid = 0;
    repeat (10) @(negedge sys_clk);

    // Randomized traffic.
    for (int i = 0; i < 5000; i++) begin
      host_valid  = ($urandom % 2) == 0;
      host_cmd    = 8'($urandom);
      host_data   = 16'($urandom);
      sweep_go    = ($urandom % 30) == 0;
      sweep_start = 14'($urandom);
      sweep_stop  = (($urandom % 2) == 0) ? sweep_start + 14'($urandom_range(0, 100))
                                          : sweep_start - 14'($urandom_range(0, 100));
      sweep_step  = (($urandom % 8) == 0) ? 14'($urandom) : 14'($urandom_range(0, 30));
      sweep_dwell = 16'($urandom_range(0, 4));
      sweep_abort = ($urandom % 150) == 0;
      sys_rst     = ($urandom % 600) == 0;
      @(negedge sys_clk);
    end
    sys_rst = 0; host_valid = 0; sweep_go = 0; sweep_abort = 0;
    repeat (5) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
